// File: rtl/host_interface_burst.sv
// host_interface_burst: GPIF-style host port bridging the PC link to the Device Interface
// Latency: host inputs registered once; device strobes issue on the edge after the registered strobe
// Backpressure: transfers stall on rd_ready/wr_ready; rdy shows device readiness or read data-valid
//
// Build option: DI_ADDR_AUTOINC_EN -- when defined, diRegAddr advances by one after every
// burst read/write word (block register access); otherwise it changes only through SETREG.
//
// Ports:
//   if_clock, resetb            interface clock (rising edge), synchronous active-low reset
//   ctl[1] rdwr_b strobe, ctl[2] transaction framing; state = host opcode; data_in = pad data
//   data_out, data_oe, rdy      pad read data, pad output enable, ready / read data-valid
//   diEpAddr, diRegAddr         endpoint and register address to the device bus
//   diRegDataIn, diRegDataOut   write data to / read data from the device
//   diWrite, diRead, diReset    one-cycle device strobes
//   rd_ready, wr_ready          device can supply / accept a word
//   burst_done                  one-cycle pulse when a burst counter reaches zero
module host_interface_burst #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int TC_W   = 16
) (
   input  logic              if_clock,
   input  logic              resetb,
   input  logic [2:0]        ctl,
   input  logic [3:0]        state,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              rdy,
   output logic [ADDR_W-1:0] diEpAddr,
   output logic [ADDR_W-1:0] diRegAddr,
   output logic [DATA_W-1:0] diRegDataIn,
   input  logic [DATA_W-1:0] diRegDataOut,
   output logic              diWrite,
   output logic              diRead,
   output logic              diReset,
   input  logic              rd_ready,
   input  logic              wr_ready,
   output logic              burst_done
);

   localparam logic [3:0] OP_SETEP     = 4'd1;
   localparam logic [3:0] OP_SETREG    = 4'd2;
   localparam logic [3:0] OP_SETRVAL   = 4'd3;
   localparam logic [3:0] OP_RDDATA    = 4'd4;
   localparam logic [3:0] OP_RESETRVAL = 4'd5;
   localparam logic [3:0] OP_GETRVAL   = 4'd6;
   localparam logic [3:0] OP_RDTC      = 4'd7;
   localparam logic [3:0] OP_WRDATA    = 4'd8;
   localparam logic [3:0] OP_WRTC      = 4'd9;

   // registered host inputs
   logic [3:0]        r_state_q;
   logic [3:0]        r_state_qq;
   logic [2:0]        r_ctl_q;
   logic              r_ctl2_qq;
   logic [DATA_W-1:0] r_data_q;

   // burst counters and their reload values
   logic [TC_W-1:0]   r_rd_tc;
   logic [TC_W-1:0]   r_rd_tc_reset;
   logic [TC_W-1:0]   r_wr_tc;
   logic [TC_W-1:0]   r_wr_tc_reset;

   // burst read return path: strobe marker, data-valid and captured word
   logic              r_rd_burst;
   logic              r_rd_vld;
   logic [DATA_W-1:0] r_data_out;

`ifdef DI_ADDR_AUTOINC_EN
   logic              r_wr_burst;
`endif

   logic              w_settle;
   logic              w_rdwr;
   logic              w_ctl2_rise;
   logic              w_rd_reload;
   logic              w_wr_reload;
   logic              w_rd_go;
   logic              w_wr_go;
   logic              w_unused_ctl0;

   // Any opcode change costs one dead cycle so a half-decoded opcode never strobes the device.
   assign w_settle      = (r_state_q != r_state_qq);
   assign w_rdwr        = r_ctl_q[1];
   assign w_ctl2_rise   = r_ctl_q[2] && !r_ctl2_qq;
   assign w_unused_ctl0 = r_ctl_q[0];

   // Reload only from an exhausted counter; a live count always takes the transfer path instead.
   assign w_rd_reload = w_ctl2_rise && (r_rd_tc == '0);
   assign w_wr_reload = w_ctl2_rise && (r_wr_tc == '0);
   assign w_rd_go     = w_rdwr && rd_ready && (r_rd_tc != '0);
   assign w_wr_go     = w_rdwr && wr_ready && (r_wr_tc != '0);

   always_ff @(posedge if_clock) begin
      if (!resetb) begin
         r_state_q     <= '0;
         r_state_qq    <= '0;
         r_ctl_q       <= '0;
         r_ctl2_qq     <= 1'b0;
         r_data_q      <= '0;
         r_rd_tc       <= '0;
         r_rd_tc_reset <= '0;
         r_wr_tc       <= '0;
         r_wr_tc_reset <= '0;
         r_rd_burst    <= 1'b0;
         r_rd_vld      <= 1'b0;
         r_data_out    <= '0;
         diEpAddr      <= '0;
         diRegAddr     <= '0;
         diRegDataIn   <= '0;
         diWrite       <= 1'b0;
         diRead        <= 1'b0;
         diReset       <= 1'b0;
         burst_done    <= 1'b0;
`ifdef DI_ADDR_AUTOINC_EN
         r_wr_burst    <= 1'b0;
`endif
      end else begin
         r_state_q  <= state;
         r_state_qq <= r_state_q;
         r_ctl_q    <= ctl;
         r_ctl2_qq  <= r_ctl_q[2];
         r_data_q   <= data_in;

         // strobes are single-cycle unless re-armed below
         diWrite    <= 1'b0;
         diRead     <= 1'b0;
         diReset    <= 1'b0;
         burst_done <= 1'b0;
         r_rd_burst <= 1'b0;

         // The device drives its word during the diRead cycle; capture it and flag it valid next cycle.
         r_rd_vld <= r_rd_burst;
         if (r_rd_burst) begin
            r_data_out <= diRegDataOut;
         end

`ifdef DI_ADDR_AUTOINC_EN
         // Advance after the strobe cycle so each word uses the address it was issued with.
         r_wr_burst <= 1'b0;
         if (r_rd_burst || r_wr_burst) begin
            diRegAddr <= diRegAddr + ADDR_W'(1);
         end
`endif

         if (!w_settle) begin
            case (r_state_q)
               OP_SETEP: begin
                  if (w_rdwr) diEpAddr <= ADDR_W'(r_data_q);
               end
               OP_SETREG: begin
                  if (w_rdwr) diRegAddr <= ADDR_W'(r_data_q);
               end
               OP_RDTC: begin
                  if (w_rdwr) begin
                     r_rd_tc       <= TC_W'(r_data_q);
                     r_rd_tc_reset <= TC_W'(r_data_q);
                  end
               end
               OP_WRTC: begin
                  if (w_rdwr) begin
                     r_wr_tc       <= TC_W'(r_data_q);
                     r_wr_tc_reset <= TC_W'(r_data_q);
                  end
               end
               OP_SETRVAL: begin
                  diWrite <= w_rdwr;
                  if (w_rdwr) diRegDataIn <= r_data_q;
               end
               OP_GETRVAL: begin
                  diRead <= w_rdwr;
               end
               OP_RESETRVAL: begin
                  diReset <= w_rdwr;
               end
               OP_RDDATA: begin
                  if (w_rd_reload) begin
                     r_rd_tc <= r_rd_tc_reset;
                  end else if (w_rd_go) begin
                     diRead     <= 1'b1;
                     r_rd_burst <= 1'b1;
                     r_rd_tc    <= r_rd_tc - TC_W'(1);
                     if (r_rd_tc == TC_W'(1)) burst_done <= 1'b1;
                  end
               end
               OP_WRDATA: begin
                  if (w_wr_reload) begin
                     r_wr_tc <= r_wr_tc_reset;
                  end else if (w_wr_go) begin
                     diWrite     <= 1'b1;
                     diRegDataIn <= r_data_q;
                     r_wr_tc     <= r_wr_tc - TC_W'(1);
                     if (r_wr_tc == TC_W'(1)) burst_done <= 1'b1;
`ifdef DI_ADDR_AUTOINC_EN
                     r_wr_burst  <= 1'b1;
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Pad-side handshake; all of it is dropped while an opcode change settles.
   always_comb begin
      rdy      = 1'b0;
      data_oe  = 1'b0;
      data_out = r_data_out;
      if (!w_settle) begin
         case (r_state_q)
            OP_SETEP, OP_SETREG, OP_RDTC, OP_WRTC, OP_RESETRVAL: begin
               rdy = 1'b1;
            end
            OP_SETRVAL: begin
               rdy = wr_ready;
            end
            OP_GETRVAL: begin
               data_oe  = 1'b1;
               data_out = diRegDataOut;
               rdy      = rd_ready;
            end
            OP_RDDATA: begin
               data_oe = 1'b1;
               rdy     = r_rd_vld;
            end
            OP_WRDATA: begin
               rdy = wr_ready && (r_wr_tc != '0);
            end
            default: ;
         endcase
      end
   end

endmodule
